serial_twos_complementer_n: RTL and testbench

- Parametrised serial complementer: a WIDTH-bit word is loaded in parallel and shifted out LSB-first through a carry-flag flip-flop and an XOR selective inverter.
- Produces the two's complement (or one's complement) serially on y, plus the reassembled parallel result.
- Start/busy/done handshake replaces externally timed shift_control.
- Sits between a parallel register source and serial consumers (serial ALU, bit-serial link).

---
 rtl/serial_twos_complementer_n.sv | 170 +++++++++++++++++
 tb/tb_serial_twos_complementer_n.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_twos_complementer_n.sv
`default_nettype none
// ============================================================================
// Module      : serial_twos_complementer_n
// Description : Bit-serial complementer. A WIDTH-bit word is loaded in
//               parallel, then shifted out LSB-first through a carry-flag
//               flip-flop and an XOR selective inverter. The serial result
//               also appears on y and is reassembled into result.
//               A start/busy/done handshake sequences one conversion.
// Ports       : Clock    - rising-edge clock
//               reset_b  - asynchronous active-low reset
//               load     - parallel load strobe (IDLE only)
//               data     - word to complement, sampled on a load edge
//               start    - begin conversion (IDLE only, load has priority)
//               mode     - 0: two's complement, 1: one's complement
//                          (2 bits with SERIAL_COMP_ABS_EN: 00 two's,
//                          01 one's, 10 absolute value, 11 as 00)
//               y        - serial result bit, 0 outside y_valid
//               y_valid  - high on each serial bit cycle (same as busy)
//               busy     - high while shifting
//               done     - one-cycle pulse, result is final
//               result   - reassembled word, held until the next load
//               is_neg   - (SERIAL_COMP_ABS_EN only) sign latched at start
// Options     : `define SERIAL_COMP_ABS_EN adds the absolute-value mode
// Revision    : 1.0 - initial release
// ============================================================================
module serial_twos_complementer_n #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             Clock,
  input  logic             reset_b,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             start,
`ifdef SERIAL_COMP_ABS_EN
  input  logic [1:0]       mode,
  output logic             is_neg,
`else
  input  logic             mode,
`endif
  output logic             y,
  output logic             y_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

`ifdef SERIAL_COMP_ABS_EN
  localparam int MODE_W = 2;
`else
  localparam int MODE_W = 1;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]        state_q,  state_d;
  logic [WIDTH-1:0]  sr_q,     sr_d;
  logic              flag_q,   flag_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [MODE_W-1:0] mode_q,   mode_d;
`ifdef SERIAL_COMP_ABS_EN
  logic              neg_q,    neg_d;
`endif

  logic w_invert;
  logic w_y_bit;

  // Selective inverter control. For two's complement the flag records that a
  // 1 has already passed, so every bit after the first 1 is inverted.
  always_comb begin
`ifdef SERIAL_COMP_ABS_EN
    case (mode_q)
      2'b01:   w_invert = 1'b1;
      2'b10:   w_invert = neg_q & flag_q;  // positive words pass through
      default: w_invert = flag_q;
    endcase
`else
    w_invert = mode_q[0] | flag_q;
`endif
  end

  assign w_y_bit = sr_q[0] ^ w_invert;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    flag_d   = flag_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    mode_d   = mode_q;
`ifdef SERIAL_COMP_ABS_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          sr_d     = data;
          flag_d   = 1'b0;
          result_d = '0;
        end else if (start) begin
          mode_d  = mode;
          cnt_d   = '0;
          // Re-arm the flag so a start without reload complements the
          // current (already shifted-out, all-zero) sr to 0 rather than
          // inheriting the previous word's carry state.
          flag_d  = 1'b0;
`ifdef SERIAL_COMP_ABS_EN
          neg_d   = sr_q[WIDTH-1];
`endif
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        result_d = {w_y_bit, result_q[WIDTH-1:1]};
        sr_d     = {1'b0, sr_q[WIDTH-1:1]};
        flag_d   = flag_q | sr_q[0];
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= ST_IDLE;
      sr_q     <= '0;
      flag_q   <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      mode_q   <= '0;
`ifdef SERIAL_COMP_ABS_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      mode_q   <= mode_d;
`ifdef SERIAL_COMP_ABS_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign busy    = (state_q == ST_SHIFT);
  assign y_valid = busy;
  assign done    = (state_q == ST_DONE);
  assign y       = busy & w_y_bit;
  assign result  = result_q;
`ifdef SERIAL_COMP_ABS_EN
  assign is_neg  = neg_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_twos_complementer_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_twos_complementer_n
// Description : Self-checking bench for serial_twos_complementer_n with a
//               WIDTH=8 instance (vector table plus corner sequences) and a
//               WIDTH=16 instance. Absolute-value vectors are included when
//               SERIAL_COMP_ABS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_twos_complementer_n;

`ifdef SERIAL_COMP_ABS_EN
  localparam int MW = 2;
`else
  localparam int MW = 1;
`endif

  logic          Clock;
  logic          reset_b;
  logic          load;
  logic [7:0]    data;
  logic          start;
  logic [MW-1:0] mode;
  logic          y, y_valid, busy, done;
  logic [7:0]    result;
  logic          is_neg;

  logic          load16;
  logic [15:0]   data16;
  logic          start16;
  logic [MW-1:0] mode16;
  logic          y16, y_valid16, busy16, done16;
  logic [15:0]   result16;
  logic          is_neg16;

  int n_checks;
  int n_pass;

  serial_twos_complementer_n #(.WIDTH(8)) dut8 (
    .Clock   (Clock),
    .reset_b (reset_b),
    .load    (load),
    .data    (data),
    .start   (start),
    .mode    (mode),
`ifdef SERIAL_COMP_ABS_EN
    .is_neg  (is_neg),
`endif
    .y       (y),
    .y_valid (y_valid),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  serial_twos_complementer_n #(.WIDTH(16)) dut16 (
    .Clock   (Clock),
    .reset_b (reset_b),
    .load    (load16),
    .data    (data16),
    .start   (start16),
    .mode    (mode16),
`ifdef SERIAL_COMP_ABS_EN
    .is_neg  (is_neg16),
`endif
    .y       (y16),
    .y_valid (y_valid16),
    .busy    (busy16),
    .done    (done16),
    .result  (result16)
  );

`ifndef SERIAL_COMP_ABS_EN
  assign is_neg   = 1'b0;
  assign is_neg16 = 1'b0;
`endif

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [7:0]    din;
    logic [MW-1:0] m;
    logic [7:0]    exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_load(input logic [7:0] d);
    load = 1'b1;
    data = d;
    tick();
    load = 1'b0;
  endtask

  // Applies start for one edge; returns during the first serial bit cycle.
  task automatic do_start(input logic [MW-1:0] m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
  endtask

  // Observes one conversion starting in the first bit cycle. Expected y
  // sequence LSB-first is the bits of exp_res, so it is compared as a word.
  task automatic watch8(input string name, input logic [7:0] exp_res, input bit inject);
    logic [7:0] ybits;
    logic [7:0] res_at_done;
    int nb, ndone, done_at, y_bad, yv_bad;
    ybits = '0; res_at_done = '0;
    nb = 0; ndone = 0; done_at = -1; y_bad = 0; yv_bad = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (y_valid !== busy) yv_bad++;
      if (busy === 1'b1) begin
        if (nb < 8) ybits[nb] = y;
        nb++;
      end else if (y !== 1'b0) begin
        y_bad++;
      end
      if (done === 1'b1) begin
        ndone++;
        done_at     = cyc;
        res_at_done = result;
      end
      if (inject && cyc == 3) begin
        load = 1'b1; data = 8'hFF; start = 1'b1; mode = '0;
      end
      if (inject && cyc == 4) begin
        load = 1'b0; start = 1'b0;
      end
      tick();
    end
    check({name, ".busy_cycles"}, nb, 8);
    check({name, ".y_seq"}, ybits, exp_res);
    check({name, ".done_count"}, ndone, 1);
    check({name, ".done_cycle"}, done_at, 9);
    check({name, ".result_at_done"}, res_at_done, exp_res);
    check({name, ".result_held"}, result, exp_res);
    check({name, ".y_idle_zero"}, y_bad, 0);
    check({name, ".yvalid_eq_busy"}, yv_bad, 0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    reset_b = 1'b0;
    load = 0; data = '0; start = 0; mode = '0;
    load16 = 0; data16 = '0; start16 = 0; mode16 = '0;

    vecs[0] = '{8'h5A, MW'(0), 8'hA6};
    vecs[1] = '{8'h33, MW'(0), 8'hCD};
    vecs[2] = '{8'h00, MW'(0), 8'h00};
    vecs[3] = '{8'h80, MW'(0), 8'h80};
    vecs[4] = '{8'h01, MW'(0), 8'hFF};
    vecs[5] = '{8'h7F, MW'(0), 8'h81};
    vecs[6] = '{8'hFF, MW'(1), 8'h00};
    vecs[7] = '{8'h5A, MW'(1), 8'hA5};

    // Reset state
    #12;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.y_valid", y_valid, 0);
    check("rst.y", y, 0);
    check("rst.result", result, 0);
    check("rst.is_neg", is_neg, 0);
    tick();
    reset_b = 1'b1;
    tick();

    foreach (vecs[i]) begin
      do_load(vecs[i].din);
      check($sformatf("vec%0d.load_clears_result", i), result, 0);
      do_start(vecs[i].m);
      watch8($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
    end

    // Back-to-back start after a one's-complement run operates on zeros.
    do_start(MW'(0));
    watch8("b2b_noreload", 8'h00, 1'b0);

    // load and start on the same edge: load wins, no conversion begins.
    load = 1'b1; data = 8'h33; start = 1'b1; mode = '0;
    tick();
    load = 1'b0; start = 1'b0;
    check("load_wins.busy", busy, 0);
    do_start(MW'(0));
    watch8("load_wins", 8'hCD, 1'b0);

    // load/start during SHIFT are ignored.
    do_load(8'h5A);
    do_start(MW'(0));
    watch8("mid_shift_ignored", 8'hA6, 1'b1);

    // Asynchronous reset at bit 4 aborts without a done pulse.
    do_load(8'h5A);
    do_start(MW'(0));
    repeat (4) tick();
    check("abort.busy_before", busy, 1);
    #2 reset_b = 1'b0;
    #1;
    check("abort.busy", busy, 0);
    check("abort.y_valid", y_valid, 0);
    check("abort.y", y, 0);
    check("abort.result", result, 0);
    check("abort.done", done, 0);
    tick();
    check("abort.done_held", done, 0);
    reset_b = 1'b1;
    tick();
    check("abort.idle_done", done, 0);
    check("abort.idle_busy", busy, 0);
    do_start(MW'(0));
    watch8("after_abort", 8'h00, 1'b0);

`ifdef SERIAL_COMP_ABS_EN
    do_load(8'hA6); do_start(2'b10); watch8("abs_A6", 8'h5A, 1'b0);
    check("abs_A6.is_neg", is_neg, 1);
    do_load(8'h5A); do_start(2'b10); watch8("abs_5A", 8'h5A, 1'b0);
    check("abs_5A.is_neg", is_neg, 0);
    do_load(8'h80); do_start(2'b10); watch8("abs_80", 8'h80, 1'b0);
    check("abs_80.is_neg", is_neg, 1);
    do_load(8'hA6); do_start(2'b11); watch8("rsv_A6", 8'h5A, 1'b0);
`endif

    // WIDTH=16: 0x0001 -> 0xFFFF over exactly 16 busy cycles.
    begin
      int nb16, nd16, done_at16;
      logic [15:0] ybits16;
      nb16 = 0; nd16 = 0; done_at16 = -1; ybits16 = '0;
      load16 = 1'b1; data16 = 16'h0001;
      tick();
      load16 = 1'b0;
      start16 = 1'b1; mode16 = '0;
      tick();
      start16 = 1'b0;
      for (int cyc = 1; cyc <= 22; cyc++) begin
        if (busy16 === 1'b1) begin
          if (nb16 < 16) ybits16[nb16] = y16;
          nb16++;
        end
        if (done16 === 1'b1) begin
          nd16++;
          done_at16 = cyc;
        end
        tick();
      end
      check("w16.busy_cycles", nb16, 16);
      check("w16.done_count", nd16, 1);
      check("w16.done_cycle", done_at16, 17);
      check("w16.y_seq", ybits16, 16'hFFFF);
      check("w16.result", result16, 16'hFFFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
